riscv_i32_dmem_access_sequencer: RTL and testbench
==================================================

# riscv_i32_dmem_access_sequencer

Sequences a single RV32I load or store from the execute stage onto the data-memory access port, splitting accesses that straddle a 32-bit word boundary into two aligned beats. For loads it drives the rotation, byte-clear, byte-enable and sign-extend controls of the dmem read-data merge datapath, and holds that datapath's `last_data` register between beats. It sits between the execute stage and the dmem access request/response interface, with the read-data merge block instantiated alongside it.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous active-low reset, sampled on `clk`.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  sequencer idle; request accepted when `req_valid && req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_address`  in  32  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `req_sign_extend`  in  1  sign-extend the load result.
- `req_write_data`  in  32  store data, right-justified.
- `flush`  in  1  abandon the in-flight access.
- `dmem_access_req__valid`  out  1  memory access request.
- `dmem_access_req__address`  out  32  word-aligned address, bits [1:0] = 0.
- `dmem_access_req__byte_enable`  out  4  memory byte lanes.
- `dmem_access_req__write_data`  out  32  lane-aligned store data.
- `dmem_access_req__write`  out  1  store beat.
- `dmem_access_req__sequential`  out  1  second beat of a split access.
- `dmem_access_resp__ack`  in  1  beat completes this cycle; read data valid this cycle.
- `read_data_rotation`  out  2  to the merge datapath.
- `read_data_byte_clear`  out  4  to the merge datapath.
- `read_data_byte_enable`  out  4  to the merge datapath.
- `sign_extend_byte`  out  1  to the merge datapath.
- `sign_extend_half`  out  1  to the merge datapath.
- `last_data`  out  32  registered partial result fed back to the merge datapath.
- `dmem_read_data`  in  32  merged result from the merge datapath.
- `resp_valid`  out  1  one-cycle pulse; access finished.
- `resp_data`  out  32  load result; 0 for stores.
- `resp_split`  out  1  qualifies `resp_valid`; access took two beats.

## Operation
- States: IDLE, BEAT0, BEAT1.
- `req_ready` = (state == IDLE).
- Acceptance registers the request and moves to BEAT0. Derived values:
  - off = addr[1:0].
  - n = 1, 2 or 4.
  - mask8 = ((1<<n)-1) << off.
  - split = (mask8[7:4] != 0).
- BEAT0 drives:
  - `dmem_access_req__address` = {addr[31:2], 2'b00}.
  - `byte_enable` = mask8[3:0].
  - `sequential` = 0.
- BEAT1 drives:
  - `dmem_access_req__address` = {addr[31:2], 2'b00} + 4, mod 2^32 (0xFFFFFFFC wraps to 0).
  - `byte_enable` = mask8[7:4].
  - `sequential` = 1.
- Store write data = `req_write_data` rotated left by 8*off, in both beats.
- Load controls in both beats:
  - `read_data_rotation` = off.
  - en0 = ((1<<n)-1) & (4'hF >> off).
- Load controls, BEAT0:
  - `read_data_byte_clear` = 4'hF.
  - `read_data_byte_enable` = en0.
- Load controls, BEAT1:
  - `read_data_byte_clear` = 4'h0.
  - `read_data_byte_enable` = ((1<<n)-1) & ~en0.
- Sign-extend on the final beat only:
  - `sign_extend_byte` = `req_sign_extend` && n == 1.
  - `sign_extend_half` = `req_sign_extend` && n == 2.
  - Both are 0 on BEAT0 of a split access and on stores.
- Beat handshake: `dmem_access_req__valid` = 1 in BEAT0 and BEAT1 and `!flush`, held until `ack`. Request fields stay stable while waiting.
- On BEAT0 `ack`:
  - `last_data` <= `dmem_read_data`.
  - If split, go to BEAT1; otherwise finish.
- On BEAT1 `ack`: finish.
- Finish:
  - `resp_valid` = 1 combinationally in the final-ack cycle.
  - `resp_data` = `dmem_read_data` for loads, 0 for stores.
  - `resp_split` = split.
  - Next state = IDLE.
- Stores write nothing to `last_data`.
- `flush` in BEAT0 or BEAT1:
  - Suppresses `valid` that cycle.
  - Next state = IDLE; no `resp_valid`.
  - `flush` takes priority over a same-cycle `ack`.
  - `flush` in IDLE has no effect and does not block acceptance.

## Timing
- Reset values:
  - State = IDLE, so `req_ready` = 1.
  - `dmem_access_req__valid` = 0, `resp_valid` = 0, `last_data` = 0.
  - Registered request fields = 0, so other outputs = 0.
- Reset mid-access returns to IDLE with no response. A late `ack` is ignored.
- Request accepted in cycle N → `dmem_access_req__valid` in cycle N+1.
- Zero-wait memory:
  - Aligned access: `resp_valid` in N+1; `req_ready` again in N+2.
  - Split access: beats in N+1 and N+2; `resp_valid` in N+2.
- Each wait cycle without `ack` adds one cycle.
- No back-to-back acceptance: IDLE always lasts at least one cycle.

## Test plan
- Aligned LW, addr 0x100, memory word 0xDEADBEEF, ack immediate:
  - One beat, `byte_enable` 4'hF.
  - `resp_data` 0xDEADBEEF in N+1; `resp_split` = 0.
- LH signed, addr 0x103:
  - Beat0 at 0x100, BE 4'h8, mem 0x80xxxxxx.
  - Beat1 at 0x104, BE 4'h1, sequential = 1, mem 0xxxxxxxFF.
  - `resp_data` 0xFFFFFF80; `resp_split` = 1.
- SW, addr 0x102, data 0x11223344:
  - Beat0: BE 4'hC, wdata 0x33441122.
  - Beat1 at 0x104: BE 4'h3, same wdata.
  - `resp_data` 0.
- LBU, addr 0x201, mem 0x0000AB00, ack delayed 3 cycles:
  - `valid` and address held 3 cycles.
  - `resp_data` 0x000000AB.
- LW, addr 0xFFFFFFFE: beat1 address is 0x00000000.
- Flush and reset interruptions:
  - Split load with `flush` asserted in BEAT1: no `resp_valid`; IDLE next cycle; new request accepted.
  - `reset_n` = 0 during BEAT0: all outputs at reset values next cycle.

Source files
------------

// File: rtl/riscv_i32_dmem_access_sequencer.sv
// riscv_i32_dmem_access_sequencer
//
// Sequences one RV32I load or store from the execute stage onto the
// word-wide data-memory access port. Accesses that cross a 32-bit word
// boundary are split into two aligned beats. For loads, the sequencer drives
// the rotation / byte-clear / byte-enable / sign-extend controls of the
// external read-data merge datapath. It also holds the merge datapath's
// partial result (last_data) between the two beats.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   req_*                        execute-stage request (valid/ready handshake)
//   flush                        abandon the in-flight access
//   dmem_access_req__*           memory beat request (word address, lanes, data)
//   dmem_access_resp__ack        current beat completes this cycle
//   read_data_*, sign_extend_*   controls to the read-data merge datapath
//   last_data                    registered partial result fed back to the merge
//   dmem_read_data               merged result from the merge datapath
//   resp_valid/resp_data/resp_split  completion pulse, load data, two-beat flag
module riscv_i32_dmem_access_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_address,
    input  logic [1:0]  req_size,
    input  logic        req_sign_extend,
    input  logic [31:0] req_write_data,
    input  logic        flush,
    output logic        dmem_access_req__valid,
    output logic [31:0] dmem_access_req__address,
    output logic [3:0]  dmem_access_req__byte_enable,
    output logic [31:0] dmem_access_req__write_data,
    output logic        dmem_access_req__write,
    output logic        dmem_access_req__sequential,
    input  logic        dmem_access_resp__ack,
    output logic [1:0]  read_data_rotation,
    output logic [3:0]  read_data_byte_clear,
    output logic [3:0]  read_data_byte_enable,
    output logic        sign_extend_byte,
    output logic        sign_extend_half,
    output logic [31:0] last_data,
    input  logic [31:0] dmem_read_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_split
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_store;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_last_data;

    logic [1:0]  w_off;
    logic [3:0]  w_mask_n;     // (1<<n)-1
    logic [7:0]  w_mask8;      // lanes across the two words touched
    logic        w_split;
    logic [3:0]  w_en0;        // result bytes delivered by the first beat
    logic [31:0] w_word_addr;
    logic [31:0] w_rot_wdata;
    logic        w_active;
    logic        w_ack;
    logic        w_final;

    assign w_off       = r_addr[1:0];
    assign w_mask_n    = (r_size == 2'd0) ? 4'h1 : (r_size == 2'd1) ? 4'h3 : 4'hF;
    assign w_mask8     = {4'b0000, w_mask_n} << w_off;
    assign w_split     = |w_mask8[7:4];
    assign w_en0       = w_mask_n & (4'hF >> w_off);
    assign w_word_addr = {r_addr[31:2], 2'b00};
    assign w_active    = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
    // flush wins over a same-cycle ack; ack outside a beat is ignored
    assign w_ack       = w_active && !flush && dmem_access_resp__ack;
    assign w_final     = (r_state == ST_BEAT1) || ((r_state == ST_BEAT0) && !w_split);
    assign last_data   = r_last_data;

    // Store data rotated left by 8*off so each byte lands on its memory lane
    always_comb begin
        w_rot_wdata = r_wdata;
        case (w_off)
            2'd1:    w_rot_wdata = {r_wdata[23:0], r_wdata[31:24]};
            2'd2:    w_rot_wdata = {r_wdata[15:0], r_wdata[31:16]};
            2'd3:    w_rot_wdata = {r_wdata[7:0],  r_wdata[31:8]};
            default: w_rot_wdata = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_store     <= 1'b0;
            r_sign      <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_last_data <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_store <= req_store;
                r_sign  <= req_sign_extend;
                r_size  <= req_size;
                r_addr  <= req_address;
                r_wdata <= req_write_data;
            end
            if (r_state == ST_BEAT0 && w_ack && !r_store) begin
                r_last_data <= dmem_read_data;
            end
        end
    end

    always_comb begin
        w_state_next                 = r_state;
        req_ready                    = (r_state == ST_IDLE);
        dmem_access_req__valid       = 1'b0;
        dmem_access_req__address     = 32'd0;
        dmem_access_req__byte_enable = 4'h0;
        dmem_access_req__write_data  = 32'd0;
        dmem_access_req__write       = 1'b0;
        dmem_access_req__sequential  = 1'b0;
        read_data_rotation           = 2'd0;
        read_data_byte_clear         = 4'h0;
        read_data_byte_enable        = 4'h0;
        sign_extend_byte             = 1'b0;
        sign_extend_half             = 1'b0;
        resp_valid                   = 1'b0;
        resp_data                    = 32'd0;
        resp_split                   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_state_next = ST_BEAT0;
            end
            ST_BEAT0: begin
                if (flush)        w_state_next = ST_IDLE;
                else if (w_ack)   w_state_next = w_split ? ST_BEAT1 : ST_IDLE;
            end
            ST_BEAT1: begin
                if (flush || w_ack) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_active) begin
            dmem_access_req__valid      = !flush;
            dmem_access_req__write      = r_store;
            dmem_access_req__sequential = (r_state == ST_BEAT1);
            if (r_state == ST_BEAT1) begin
                dmem_access_req__address     = w_word_addr + 32'd4;
                dmem_access_req__byte_enable = w_mask8[7:4];
            end else begin
                dmem_access_req__address     = w_word_addr;
                dmem_access_req__byte_enable = w_mask8[3:0];
            end
            if (r_store) begin
                dmem_access_req__write_data = w_rot_wdata;
            end else begin
                read_data_rotation = w_off;
                // First beat clears the result; second beat merges into last_data
                if (r_state == ST_BEAT0) begin
                    read_data_byte_clear  = 4'hF;
                    read_data_byte_enable = w_en0;
                end else begin
                    read_data_byte_enable = w_mask_n & ~w_en0;
                end
                if (w_final) begin
                    sign_extend_byte = r_sign && (r_size == 2'd0);
                    sign_extend_half = r_sign && (r_size == 2'd1);
                end
            end
        end

        if (w_ack && w_final) begin
            resp_valid = 1'b1;
            resp_data  = r_store ? 32'd0 : dmem_read_data;
            resp_split = w_split;
        end
    end

endmodule

// File: tb/tb_riscv_i32_dmem_access_sequencer.sv
module tb_riscv_i32_dmem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_store, req_sign_extend, flush;
    logic [31:0] req_address, req_write_data;
    logic [1:0]  req_size;
    logic        dmem_access_req__valid, dmem_access_req__write, dmem_access_req__sequential;
    logic [31:0] dmem_access_req__address, dmem_access_req__write_data;
    logic [3:0]  dmem_access_req__byte_enable;
    logic        ack;
    logic [1:0]  read_data_rotation;
    logic [3:0]  read_data_byte_clear, read_data_byte_enable;
    logic        sign_extend_byte, sign_extend_half;
    logic [31:0] last_data, dmem_read_data, resp_data;
    logic        resp_valid, resp_split;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    logic [31:0] mem_pre [logic [31:0]];

    always #5 clk = ~clk;

    riscv_i32_dmem_access_sequencer dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .req_valid                    (req_valid),
        .req_ready                    (req_ready),
        .req_store                    (req_store),
        .req_address                  (req_address),
        .req_size                     (req_size),
        .req_sign_extend              (req_sign_extend),
        .req_write_data               (req_write_data),
        .flush                        (flush),
        .dmem_access_req__valid       (dmem_access_req__valid),
        .dmem_access_req__address     (dmem_access_req__address),
        .dmem_access_req__byte_enable (dmem_access_req__byte_enable),
        .dmem_access_req__write_data  (dmem_access_req__write_data),
        .dmem_access_req__write       (dmem_access_req__write),
        .dmem_access_req__sequential  (dmem_access_req__sequential),
        .dmem_access_resp__ack        (ack),
        .read_data_rotation           (read_data_rotation),
        .read_data_byte_clear         (read_data_byte_clear),
        .read_data_byte_enable        (read_data_byte_enable),
        .sign_extend_byte             (sign_extend_byte),
        .sign_extend_half             (sign_extend_half),
        .last_data                    (last_data),
        .dmem_read_data               (dmem_read_data),
        .resp_valid                   (resp_valid),
        .resp_data                    (resp_data),
        .resp_split                   (resp_split)
    );

    // ---------------- memory and reference model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem_pre.exists(wa)) return mem_pre[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Load result straight from the byte-addressed memory view
    function automatic logic [31:0] exp_load(input logic [31:0] addr, input int n, input logic sext);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem_byte(addr + k);
        if (sext && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sext && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Lanes of word wa touched by bytes addr .. addr+n-1
    function automatic logic [3:0] exp_be(input logic [31:0] addr, input int n, input logic [31:0] wa);
        logic [3:0]  be;
        logic [31:0] a;
        be = 4'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            if ({a[31:2], 2'b00} == wa) be[a[1:0]] = 1'b1;
        end
        return be;
    endfunction

    // Memory lane j carries store byte (j - off) mod 4
    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int off);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*((j - off + 4) % 4) +: 8];
        return w;
    endfunction

    // Model of the external read-data merge datapath
    function automatic logic [31:0] merge_model(input logic [31:0] mw, input logic [1:0] rot,
                                                input logic [3:0] clr, input logic [3:0] en,
                                                input logic sb, input logic sh, input logic [31:0] last);
        logic [31:0] r, o;
        r = (mw >> (8 * rot)) | (mw << (32 - 8 * rot));
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = en[i] ? r[8*i +: 8] : (clr[i] ? 8'h00 : last[8*i +: 8]);
        if (sb) o = {{24{o[7]}}, o[7:0]};
        else if (sh) o = {{16{o[15]}}, o[15:0]};
        return o;
    endfunction

    // ---------------- one access, checked beat by beat ----------------
    task automatic do_access(input logic st, input logic [31:0] addr, input logic [1:0] size,
                             input logic sext, input logic [31:0] wd, input int delay,
                             input int flush_beat, input logic idle_flush);
        int          n, off, nb;
        logic        split, fl, fin, got_flush, last_beat;
        logic [31:0] wa0, wa1, exp_addr, exp_data, exp_w, beat0_merged;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        split = (off + n > 4);
        nb    = split ? 2 : 1;
        wa0   = {addr[31:2], 2'b00};
        wa1   = wa0 + 32'd4;
        exp_data = st ? 32'd0 : exp_load(addr, n, sext);
        exp_w    = exp_wdata(wd, off);
        beat0_merged = 32'd0;
        got_flush = 1'b0;

        req_valid = 1'b1; req_store = st; req_address = addr; req_size = size;
        req_sign_extend = sext; req_write_data = wd; flush = idle_flush; ack = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        req_address = $urandom; req_write_data = $urandom; req_size = 2'($urandom);
        req_store = 1'($urandom); req_sign_extend = 1'($urandom);

        for (int b = 0; b < nb && !got_flush; b++) begin
            exp_addr  = (b == 0) ? wa0 : wa1;
            last_beat = (b == nb - 1);
            for (int w = 0; w <= delay && !got_flush; w++) begin
                fl  = (b == flush_beat) && (w == 0);
                fin = (w == delay);
                flush = fl;
                ack   = fl || fin;
                #1;
                dmem_read_data = merge_model(mem_word(dmem_access_req__address), read_data_rotation,
                                             read_data_byte_clear, read_data_byte_enable,
                                             sign_extend_byte, sign_extend_half, last_data);
                #1;
                n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", req_ready); end
                n_vec++; if (dmem_access_req__valid !== !fl) begin n_err++; $display("FAIL beat_valid: got %b want %b", dmem_access_req__valid, !fl); end
                n_vec++; if (dmem_access_req__address !== exp_addr) begin n_err++; $display("FAIL beat_addr: got %h want %h", dmem_access_req__address, exp_addr); end
                n_vec++; if (dmem_access_req__byte_enable !== exp_be(addr, n, exp_addr)) begin n_err++; $display("FAIL beat_be: got %h want %h", dmem_access_req__byte_enable, exp_be(addr, n, exp_addr)); end
                n_vec++; if (dmem_access_req__sequential !== (b == 1)) begin n_err++; $display("FAIL beat_seq: got %b want %b", dmem_access_req__sequential, (b == 1)); end
                n_vec++; if (dmem_access_req__write !== st) begin n_err++; $display("FAIL beat_write: got %b want %b", dmem_access_req__write, st); end
                if (st) begin
                    n_vec++; if (dmem_access_req__write_data !== exp_w) begin n_err++; $display("FAIL beat_wdata: got %h want %h", dmem_access_req__write_data, exp_w); end
                end
                if (!st && b == 1) begin
                    n_vec++; if (last_data !== beat0_merged) begin n_err++; $display("FAIL last_data: got %h want %h", last_data, beat0_merged); end
                end
                if (!st && b == 0 && split) begin
                    n_vec++; if ({sign_extend_byte, sign_extend_half} !== 2'b00) begin n_err++; $display("FAIL beat0_sext: got %b want 00", {sign_extend_byte, sign_extend_half}); end
                end
                if (fl) begin
                    got_flush = 1'b1;
                    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp: got %b want 0", resp_valid); end
                end else if (fin) begin
                    n_vec++; if (resp_valid !== last_beat) begin n_err++; $display("FAIL resp_valid: got %b want %b", resp_valid, last_beat); end
                    if (last_beat) begin
                        n_vec++; if (resp_data !== exp_data) begin n_err++; $display("FAIL resp_data: got %h want %h", resp_data, exp_data); end
                        n_vec++; if (resp_split !== split) begin n_err++; $display("FAIL resp_split: got %b want %b", resp_split, split); end
                    end
                    if (b == 0) beat0_merged = dmem_read_data;
                end else begin
                    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wait_resp: got %b want 0", resp_valid); end
                end
                @(negedge clk);
                flush = 1'b0; ack = 1'b0; dmem_read_data = $urandom;
            end
        end
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL done_ready: got %b want 1", req_ready); end
        n_vec++; if (dmem_access_req__valid !== 1'b0) begin n_err++; $display("FAIL done_valid: got %b want 0", dmem_access_req__valid); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL done_resp: got %b want 0", resp_valid); end
        n_txn++;
        $display("txn %0d: %s addr=%h size=%0d sext=%b beats=%0d delay=%0d flushed=%b exp=%h",
                 n_txn, st ? "ST" : "LD", addr, size, sext, nb, delay, got_flush, exp_data);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0; ack = 1'b0;
        req_store = 1'b0; req_address = 32'd0; req_size = 2'd0; req_sign_extend = 1'b0;
        req_write_data = 32'd0; dmem_read_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_vec++; if (dmem_access_req__valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", dmem_access_req__valid); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp: got %b want 0", resp_valid); end
        n_vec++; if (last_data !== 32'd0) begin n_err++; $display("FAIL rst_last: got %h want 0", last_data); end
        n_vec++; if (dmem_access_req__address !== 32'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", dmem_access_req__address); end
        n_vec++; if (dmem_access_req__byte_enable !== 4'h0) begin n_err++; $display("FAIL rst_be: got %h want 0", dmem_access_req__byte_enable); end
        n_vec++; if (read_data_byte_clear !== 4'h0) begin n_err++; $display("FAIL rst_clr: got %h want 0", read_data_byte_clear); end
        reset_n = 1'b1;
        @(negedge clk);
        // Reset while waiting in the first beat
        req_valid = 1'b1; req_store = 1'b0; req_address = 32'h300; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (dmem_access_req__valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", dmem_access_req__valid); end
        reset_n = 1'b0; ack = 1'b1; dmem_read_data = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        n_vec++; if (dmem_access_req__valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", dmem_access_req__valid); end
        n_vec++; if (last_data !== 32'd0) begin n_err++; $display("FAIL midrst_last: got %h want 0", last_data); end
        n_vec++; if (dmem_access_req__byte_enable !== 4'h0) begin n_err++; $display("FAIL midrst_be: got %h want 0", dmem_access_req__byte_enable); end
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL late_ack: got %b want 0", resp_valid); end
        ack = 1'b0;
        @(negedge clk);
        n_txn++;
        $display("txn %0d: reset during beat0 and late ack", n_txn);
    endtask

    task automatic test_directed();
        mem_pre[32'h100] = 32'hDEADBEEF;
        do_access(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, 0, -1, 1'b0);
        mem_pre[32'h100] = 32'h80123456;
        mem_pre[32'h104] = 32'h345678FF;
        do_access(1'b0, 32'h103, 2'd1, 1'b1, 32'd0, 0, -1, 1'b0);
        do_access(1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344, 0, -1, 1'b0);
        mem_pre[32'h200] = 32'h0000AB00;
        do_access(1'b0, 32'h201, 2'd0, 1'b0, 32'd0, 3, -1, 1'b0);
        do_access(1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'd0, 1, -1, 1'b0);
    endtask

    task automatic test_flush();
        do_access(1'b0, 32'h1FE, 2'd2, 1'b1, 32'd0, 0, 1, 1'b0);
        do_access(1'b0, 32'h404, 2'd2, 1'b0, 32'd0, 0, -1, 1'b1);
        do_access(1'b1, 32'h505, 2'd1, 1'b0, 32'hA5A55A5A, 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // req_valid held high: acceptance only from IDLE, never in a beat
        req_valid = 1'b1; req_store = 1'b0; req_address = 32'h600; req_size = 2'd2; ack = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b want 0", req_ready); end
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_resp: got %b want 1", resp_valid); end
        @(negedge clk);
        ack = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got %b want 1", req_ready); end
        n_vec++; if (dmem_access_req__valid !== 1'b0) begin n_err++; $display("FAIL b2b_novalid: got %b want 0", dmem_access_req__valid); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_vec++; if (dmem_access_req__valid !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b want 1", dmem_access_req__valid); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        n_txn++;
        $display("txn %0d: back-to-back request held valid", n_txn);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          fb;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            do_access(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom,
                      int'($urandom_range(0, 2)), fb, 1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
